// File: rtl/class_gen_acc_if.sv
// Sample-input and readout bus of the HDC class generator.
// master: trainer/loader side; slave: class_gen_acc.
interface class_gen_acc_if #(
  parameter int HV_DIM  = 10,
  parameter int CLASS_W = 5,
  parameter int CNT_W   = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [CLASS_W-1:0]  in_class;
  logic [HV_DIM-1:0]   in_hv;
  logic [CLASS_W-1:0]  rd_class;
  logic [HV_DIM-1:0]   rd_hv;
  logic [CNT_W-1:0]    rd_count;

  modport master (
    output in_valid, in_class, in_hv, rd_class,
    input  in_ready, rd_hv, rd_count
  );

  modport slave (
    input  in_valid, in_class, in_hv, rd_class,
    output in_ready, rd_hv, rd_count
  );
endinterface

// File: rtl/class_gen_acc.sv
// class_gen_acc: accumulates labelled training hypervectors into per-class,
// per-bit saturating counters and thresholds them (one class per cycle) into
// sparse binary class hypervectors, read back through an addressed port.
// Optional build macro CLASS_GEN_MAJORITY_EN: per-class threshold becomes
// ceil(sample_cnt/2) and the thresh port is ignored.
module class_gen_acc #(
  parameter int HV_DIM      = 10,
  parameter int NUM_CLASSES = 26,
  parameter int CLASS_W     = 5,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  class_gen_acc_if.slave   bus,
  input  logic [CNT_W-1:0] thresh,
  input  logic             final_start,
  input  logic             clear_start,
  output logic             busy,
  output logic             done,
  output logic             err_class
);

  typedef enum logic [1:0] {IDLE, FINAL, CLEAR} state_t;

  localparam logic [CLASS_W:0]   NC_EXT = (CLASS_W+1)'(NUM_CLASSES);
  localparam logic [CLASS_W-1:0] K_LAST = CLASS_W'(NUM_CLASSES-1);

  state_t             state_q, state_d;
  logic [CLASS_W-1:0] k_q, k_d;
  logic               done_d, err_d;
  logic               acc_en, fin_en, clr_en;
  logic               in_class_ok, rd_class_ok;
  logic [CNT_W:0]     thr;
  logic [HV_DIM-1:0]  fin_hv;

  logic [CNT_W-1:0]   cnt        [NUM_CLASSES][HV_DIM];
  logic [CNT_W-1:0]   sample_cnt [NUM_CLASSES];
  logic [HV_DIM-1:0]  class_hv   [NUM_CLASSES];

  assign in_class_ok  = ({1'b0, bus.in_class} < NC_EXT);
  assign rd_class_ok  = ({1'b0, bus.rd_class} < NC_EXT);
  assign bus.in_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);

  // Threshold the counters of class k_q into its binary hypervector.
  always_comb begin
    fin_hv = '0;
`ifdef CLASS_GEN_MAJORITY_EN
    thr = ({1'b0, sample_cnt[k_q]} + (CNT_W+1)'(1)) >> 1;
`else
    thr = {1'b0, thresh};
`endif
    for (int unsigned i = 0; i < HV_DIM; i++) begin
      fin_hv[i] = (cnt[k_q][i] != '0) && ({1'b0, cnt[k_q][i]} >= thr);
    end
  end

`ifdef CLASS_GEN_MAJORITY_EN
  logic unused_thresh;
  assign unused_thresh = ^thresh;
`endif

  // Next-state and control decode; a start wins over a same-cycle sample.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    acc_en  = 1'b0;
    fin_en  = 1'b0;
    clr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          k_d     = '0;
        end else if (final_start) begin
          state_d = FINAL;
          k_d     = '0;
        end else if (bus.in_valid) begin
          if (in_class_ok) acc_en = 1'b1;
          else             err_d  = 1'b1;
        end
      end
      FINAL, CLEAR: begin
        fin_en = (state_q == FINAL);
        clr_en = (state_q == CLEAR);
        if (k_q == K_LAST) begin
          state_d = IDLE;
          k_d     = '0;
          done_d  = 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, class index and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      done      <= 1'b0;
      err_class <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      done      <= done_d;
      err_class <= err_d;
    end
  end

  // Per-bit and per-class saturating counters: accumulate or clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
        sample_cnt[c] <= '0;
        for (int unsigned i = 0; i < HV_DIM; i++) cnt[c][i] <= '0;
      end
    end else if (acc_en) begin
      for (int unsigned i = 0; i < HV_DIM; i++) begin
        if (bus.in_hv[i] && (cnt[bus.in_class][i] != '1))
          cnt[bus.in_class][i] <= cnt[bus.in_class][i] + 1'b1;
      end
      if (sample_cnt[bus.in_class] != '1)
        sample_cnt[bus.in_class] <= sample_cnt[bus.in_class] + 1'b1;
    end else if (clr_en) begin
      sample_cnt[k_q] <= '0;
      for (int unsigned i = 0; i < HV_DIM; i++) cnt[k_q][i] <= '0;
    end
  end

  // Class hypervector store, written one class per FINAL cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CLASSES; c++) class_hv[c] <= '0;
    end else if (fin_en) begin
      class_hv[k_q] <= fin_hv;
    end
  end

  // Registered readout; out-of-range addresses read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_hv    <= '0;
      bus.rd_count <= '0;
    end else if (rd_class_ok) begin
      bus.rd_hv    <= class_hv[bus.rd_class];
      bus.rd_count <= sample_cnt[bus.rd_class];
    end else begin
      bus.rd_hv    <= '0;
      bus.rd_count <= '0;
    end
  end

endmodule

// File: tb/tb_class_gen_acc.sv
// Self-checking bench for class_gen_acc: directed vectors, hand-written
// command sequences and random training checked against a behavioural model.
module tb_class_gen_acc;

  localparam int NC  = 26;
  localparam int HVD = 10;
`ifdef CLASS_GEN_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] thresh;
  logic       final_start, clear_start;
  logic       busy, done, err_class;

  logic [3:0] thresh4;
  logic       final4, clear4;
  logic       busy4, done4, err4;

  int n_checks = 0;
  int n_fail   = 0;

  class_gen_acc_if #(.HV_DIM(10), .CLASS_W(5), .CNT_W(8)) bus ();
  class_gen_acc_if #(.HV_DIM(10), .CLASS_W(5), .CNT_W(4)) bus4 ();

  class_gen_acc #(.HV_DIM(10), .NUM_CLASSES(26), .CLASS_W(5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .thresh(thresh),
    .final_start(final_start), .clear_start(clear_start),
    .busy(busy), .done(done), .err_class(err_class)
  );

  class_gen_acc #(.HV_DIM(10), .NUM_CLASSES(26), .CLASS_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .thresh(thresh4),
    .final_start(final4), .clear_start(clear4),
    .busy(busy4), .done(done4), .err_class(err4)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Behavioural model: plain integer counts, thresholding from the rules.
  int unsigned       m_cnt  [NC][HVD];
  int unsigned       m_scnt [NC];
  logic [HVD-1:0]    m_hv   [NC];

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_scnt[c] = 0;
      m_hv[c]   = '0;
      for (int i = 0; i < HVD; i++) m_cnt[c][i] = 0;
    end
  endfunction

  function automatic void model_acc(int c, logic [HVD-1:0] hv);
    if (c < NC) begin
      for (int i = 0; i < HVD; i++)
        if (hv[i] && m_cnt[c][i] < 255) m_cnt[c][i]++;
      if (m_scnt[c] < 255) m_scnt[c]++;
    end
  endfunction

  function automatic void model_final(int th);
    int unsigned t;
    for (int c = 0; c < NC; c++) begin
      t = MAJ ? (m_scnt[c] + 1) / 2 : th;
      for (int i = 0; i < HVD; i++)
        m_hv[c][i] = (m_cnt[c][i] != 0) && (m_cnt[c][i] >= t);
    end
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < NC; c++) begin
      m_scnt[c] = 0;
      for (int i = 0; i < HVD; i++) m_cnt[c][i] = 0;
    end
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int c, logic [HVD-1:0] hv);
    bus.in_valid = 1'b1;
    bus.in_class = 5'(c);
    bus.in_hv    = hv;
    tick();
    bus.in_valid = 1'b0;
    model_acc(c, hv);
  endtask

  task automatic rd_check(int c);
    logic [HVD-1:0] eh;
    int unsigned    ec;
    eh = (c < NC) ? m_hv[c] : '0;
    ec = (c < NC) ? m_scnt[c] : 0;
    bus.rd_class = 5'(c);
    tick();
    check($sformatf("rd_hv[%0d]", c), 32'(bus.rd_hv), 32'(eh));
    check($sformatf("rd_count[%0d]", c), 32'(bus.rd_count), ec);
  endtask

  task automatic read_all();
    for (int c = 0; c < NC; c++) rd_check(c);
  endtask

  // Expects the FSM to be in its first busy cycle; walks through to done.
  task automatic run_busy(string tag);
    int nb = 0;
    for (int j = 0; j < NC; j++) begin
      if (busy === 1'b1 && done === 1'b0 && bus.in_ready === 1'b0) nb++;
      tick();
    end
    check({tag, "_busy_cycles"}, nb, NC);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_idle_busy"}, 32'(busy), 0);
    check({tag, "_idle_ready"}, 32'(bus.in_ready), 1);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  task automatic finalize(int th, string tag);
    thresh      = 8'(th);
    final_start = 1'b1;
    tick();
    final_start = 1'b0;
    run_busy(tag);
    model_final(th);
  endtask

  task automatic clear_all(string tag);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    run_busy(tag);
    model_clear();
  endtask

  typedef struct {
    int             cls;
    logic [HVD-1:0] hv;
    bit             exp_err;
    int             exp_count;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst = 1'b1;
    thresh = '0; final_start = 1'b0; clear_start = 1'b0;
    bus.in_valid = 1'b0; bus.in_class = '0; bus.in_hv = '0; bus.rd_class = '0;
    thresh4 = '0; final4 = 1'b0; clear4 = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_class = '0; bus4.in_hv = '0; bus4.rd_class = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err_class), 0);
    check("rst_rd_hv", 32'(bus.rd_hv), 0);
    check("rst_rd_count", 32'(bus.rd_count), 0);
    read_all();

    // Narrow-counter instance: saturation at 15
    bus4.in_valid = 1'b1; bus4.in_class = 5'd1; bus4.in_hv = 10'h3FF;
    repeat (20) tick();
    bus4.in_valid = 1'b0;
    thresh4 = 4'd15; final4 = 1'b1; tick(); final4 = 1'b0;
    repeat (NC) tick();
    check("w4_done_t15", 32'(done4), 1);
    bus4.rd_class = 5'd1; tick();
    check("w4_hv_t15", 32'(bus4.rd_hv), 32'h3FF);
    check("w4_count_sat", 32'(bus4.rd_count), 15);
    bus4.rd_class = 5'd0; tick();
    check("w4_class0_hv", 32'(bus4.rd_hv), 0);
    thresh4 = 4'd0; final4 = 1'b1; tick(); final4 = 1'b0;
    repeat (NC) tick();
    check("w4_done_t0", 32'(done4), 1);
    bus4.rd_class = 5'd1; tick();
    check("w4_hv_t0", 32'(bus4.rd_hv), 32'h3FF);

    // Directed vectors: err_class pulse and resulting sample count
    vecs[0] = '{cls: 3,  hv: 10'h3FF, exp_err: 1'b0, exp_count: 1};
    vecs[1] = '{cls: 3,  hv: 10'h001, exp_err: 1'b0, exp_count: 2};
    vecs[2] = '{cls: 26, hv: 10'h3FF, exp_err: 1'b1, exp_count: 0};
    vecs[3] = '{cls: 31, hv: 10'h3FF, exp_err: 1'b1, exp_count: 0};
    vecs[4] = '{cls: 25, hv: 10'h2AA, exp_err: 1'b0, exp_count: 1};
    vecs[5] = '{cls: 3,  hv: 10'h155, exp_err: 1'b0, exp_count: 3};
    vecs[6] = '{cls: 7,  hv: 10'h000, exp_err: 1'b0, exp_count: 1};
    vecs[7] = '{cls: 25, hv: 10'h3FF, exp_err: 1'b0, exp_count: 2};
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].cls, vecs[v].hv);
      check($sformatf("vec%0d_err", v), 32'(err_class), 32'(vecs[v].exp_err));
      tick();
      check($sformatf("vec%0d_err_clr", v), 32'(err_class), 0);
      bus.rd_class = 5'(vecs[v].cls);
      tick();
      check($sformatf("vec%0d_count", v), 32'(bus.rd_count), vecs[v].exp_count);
    end

    // Class 0 training sequence
    for (int n = 0; n < 15; n++) send(0, 10'b1111001111);
    for (int n = 0; n < 20; n++) send(0, 10'b0000000001);
    finalize(16, "fin_c0");
    bus.rd_class = 5'd0; tick();
    check("c0_hv", 32'(bus.rd_hv), 32'h001);
    check("c0_count", 32'(bus.rd_count), 35);
    bus.rd_class = 5'd1; tick();
    check("c1_hv", 32'(bus.rd_hv), 0);
    read_all();

    // Out-of-range class leaves counts untouched
    send(26, 10'h3FF);
    check("bad_err", 32'(err_class), 1);
    tick();
    check("bad_err_once", 32'(err_class), 0);
    bus.rd_class = 5'd0; tick();
    check("bad_c0_count", 32'(bus.rd_count), 35);
    finalize(16, "fin_bad");
    read_all();

    // clear_start and final_start together, plus a same-cycle sample
    clear_start = 1'b1; final_start = 1'b1;
    bus.in_valid = 1'b1; bus.in_class = 5'd0; bus.in_hv = 10'h3FF;
    tick();
    clear_start = 1'b0; final_start = 1'b0; bus.in_valid = 1'b0;
    run_busy("clr_fin");
    model_clear();
    bus.rd_class = 5'd0; tick();
    check("clr_c0_hv_kept", 32'(bus.rd_hv), 32'h001);
    check("clr_c0_count", 32'(bus.rd_count), 0);
    finalize(16, "fin_after_clr");
    bus.rd_class = 5'd0; tick();
    check("clr_c0_hv_zero", 32'(bus.rd_hv), 0);
    read_all();

    // Random training against the model
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 40; n++) begin
        int c;
        logic [HVD-1:0] hv;
        c  = (($urandom % 8) == 0) ? int'($urandom_range(26, 31)) : int'($urandom_range(0, 25));
        hv = 10'($urandom);
        send(c, hv);
        check("rnd_err", 32'(err_class), (c >= NC) ? 1 : 0);
      end
      finalize(int'($urandom_range(0, 4)), "fin_rnd");
      read_all();
      rd_check(27);
      if (r == 1) clear_all("clr_rnd");
    end

    // Reset during FINAL at k=10
    thresh = 8'd1; final_start = 1'b1; tick(); final_start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("midrst_done", 32'(done), 0);
    check("midrst_ready", 32'(bus.in_ready), 1);
    check("midrst_busy", 32'(busy), 0);
    tick();
    check("midrst_no_done", 32'(done), 0);
    read_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
